// File: rtl/cache_memory_sa.sv
// cache_memory_sa
//   N-way set-associative, write-back, write-allocate cache between the CPU
//   load/store port and a slower backing memory. Hits complete in one cycle.
//   Misses run an optional writeback followed by a fill (loads only) over a
//   req/ack handshake. All outputs are registered.
//
// Parameters
//   WAYS  associativity (1, 2 or 4)
//   SETS  sets per way (power of two, >= 2)
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   addr, write_data         CPU word address (bits [1:0] ignored) and store data
//   mem_read, mem_write      request strobes, sampled while busy=0 (write wins)
//   read_data, hit, done     completion pulse with hit flag and load result
//   busy                     miss in progress, requests ignored
//   bm_req, bm_we, bm_addr,
//   bm_wdata                 backing-memory request (we=1 writeback, 0 fill)
//   bm_rdata, bm_ack         backing-memory fill data and one-cycle acknowledge
//
// Build option
//   CACHE_STATS_EN  adds saturating hit_count / miss_count outputs.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting requests; hits served here in one cycle
// WB    | writing the dirty victim line back to backing memory
// FILL  | fetching the requested word for a load miss
// RESP  | installing the line, pulsing done, returning to IDLE

module cache_memory_sa #(
    parameter int WAYS = 2,
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        done,
    output logic        busy,
    output logic        bm_req,
    output logic        bm_we,
    output logic [31:0] bm_addr,
    output logic [31:0] bm_wdata,
    input  logic [31:0] bm_rdata,
    input  logic        bm_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;

    state_t state_q, state_d;

    logic             valid_q [WAYS][SETS];
    logic             dirty_q [WAYS][SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS];
    logic [WW-1:0]    vptr_q  [SETS];

    logic             rq_store_q;
    logic [31:0]      rq_wdata_q;
    logic [TAG_W-1:0] rq_tag_q;
    logic [IDX_W-1:0] rq_idx_q;
    logic [WW-1:0]    vic_way_q;
    logic             vic_valid_q;
    logic [31:0]      fill_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_addr_bits;

    assign req_idx          = addr[2 +: IDX_W];
    assign req_tag          = addr[31 -: TAG_W];
    assign unused_addr_bits = ^addr[1:0];

    // Lookup and victim choice, both combinational in the request cycle.
    logic          lk_hit;
    logic [WW-1:0] lk_way;
    logic          vic_found;
    logic [WW-1:0] vic_way_c;
    logic          vic_valid_c;
    logic          vic_dirty_c;

    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        vic_found = 1'b0;
        vic_way_c = vptr_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                lk_hit = 1'b1;
                lk_way = WW'(w);
            end
            if (!vic_found && !valid_q[w][req_idx]) begin
                vic_found = 1'b1;
                vic_way_c = WW'(w);
            end
        end
        vic_valid_c = valid_q[vic_way_c][req_idx];
        vic_dirty_c = dirty_q[vic_way_c][req_idx];
    end

    logic        busy_d, done_d, hit_d;
    logic [31:0] read_data_d;
    logic        bm_req_d, bm_we_d;
    logic [31:0] bm_addr_d, bm_wdata_d;
    logic        store_hit, miss_accept, install, fill_take;
    logic        bm_fire;

    // An ack only counts while a request is actually outstanding.
    assign bm_fire = bm_req && bm_ack;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy;
        done_d      = 1'b0;
        hit_d       = 1'b0;
        read_data_d = read_data;
        bm_req_d    = bm_req;
        bm_we_d     = bm_we;
        bm_addr_d   = bm_addr;
        bm_wdata_d  = bm_wdata;
        store_hit   = 1'b0;
        miss_accept = 1'b0;
        install     = 1'b0;
        fill_take   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    if (lk_hit) begin
                        done_d = 1'b1;
                        hit_d  = 1'b1;
                        if (mem_write) begin
                            store_hit = 1'b1;
                        end else begin
                            read_data_d = data_q[lk_way][req_idx];
                        end
                    end else begin
                        miss_accept = 1'b1;
                        busy_d      = 1'b1;
                        if (vic_valid_c && vic_dirty_c) begin
                            state_d    = S_WB;
                            bm_req_d   = 1'b1;
                            bm_we_d    = 1'b1;
                            bm_addr_d  = {tag_q[vic_way_c][req_idx], req_idx, 2'b00};
                            bm_wdata_d = data_q[vic_way_c][req_idx];
                        end else if (mem_write) begin
                            // Whole-word store: nothing to fetch.
                            state_d = S_RESP;
                        end else begin
                            state_d   = S_FILL;
                            bm_req_d  = 1'b1;
                            bm_we_d   = 1'b0;
                            bm_addr_d = {req_tag, req_idx, 2'b00};
                        end
                    end
                end
            end
            S_WB: begin
                if (bm_fire) begin
                    if (rq_store_q) begin
                        state_d  = S_RESP;
                        bm_req_d = 1'b0;
                    end else begin
                        state_d   = S_FILL;
                        bm_we_d   = 1'b0;
                        bm_addr_d = {rq_tag_q, rq_idx_q, 2'b00};
                    end
                end
            end
            S_FILL: begin
                if (bm_fire) begin
                    fill_take = 1'b1;
                    bm_req_d  = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                install = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!rq_store_q) begin
                    read_data_d = fill_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit         <= 1'b0;
            read_data   <= '0;
            bm_req      <= 1'b0;
            bm_we       <= 1'b0;
            bm_addr     <= '0;
            bm_wdata    <= '0;
            rq_store_q  <= 1'b0;
            rq_wdata_q  <= '0;
            rq_tag_q    <= '0;
            rq_idx_q    <= '0;
            vic_way_q   <= '0;
            vic_valid_q <= 1'b0;
            fill_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            hit       <= hit_d;
            read_data <= read_data_d;
            bm_req    <= bm_req_d;
            bm_we     <= bm_we_d;
            bm_addr   <= bm_addr_d;
            bm_wdata  <= bm_wdata_d;
            if (miss_accept) begin
                rq_store_q  <= mem_write;
                rq_wdata_q  <= write_data;
                rq_tag_q    <= req_tag;
                rq_idx_q    <= req_idx;
                vic_way_q   <= vic_way_c;
                vic_valid_q <= vic_valid_c;
            end
            if (fill_take) begin
                fill_q <= bm_rdata;
            end
        end
    end

    // Line storage. Tags and data need no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                vptr_q[s] <= '0;
            end
        end else begin
            if (store_hit) begin
                data_q[lk_way][req_idx]  <= write_data;
                dirty_q[lk_way][req_idx] <= 1'b1;
            end
            if (install) begin
                valid_q[vic_way_q][rq_idx_q] <= 1'b1;
                tag_q[vic_way_q][rq_idx_q]   <= rq_tag_q;
                data_q[vic_way_q][rq_idx_q]  <= rq_store_q ? rq_wdata_q : fill_q;
                dirty_q[vic_way_q][rq_idx_q] <= rq_store_q;
                // Filling an empty way leaves the round-robin order untouched.
                if ((WAYS > 1) && vic_valid_q) begin
                    vptr_q[rq_idx_q] <= vptr_q[rq_idx_q] + WW'(1);
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (done_d) begin
            if (hit_d) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_memory_sa.sv
module tb_cache_memory_sa;

    localparam int WAYS = 2;
    localparam int SETS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] read_data;
    logic        hit;
    logic        done;
    logic        busy;
    logic        bm_req;
    logic        bm_we;
    logic [31:0] bm_addr;
    logic [31:0] bm_wdata;
    logic [31:0] bm_rdata = '0;
    logic        bm_ack = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    cache_memory_sa #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .hit        (hit),
        .done       (done),
        .busy       (busy),
        .bm_req     (bm_req),
        .bm_we      (bm_we),
        .bm_addr    (bm_addr),
        .bm_wdata   (bm_wdata),
        .bm_rdata   (bm_rdata),
        .bm_ack     (bm_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: each set holds WAYS lines keyed by full word address.
    bit          m_valid [WAYS][SETS];
    bit          m_dirty [WAYS][SETS];
    logic [31:0] m_la    [WAYS][SETS];
    logic [31:0] m_data  [WAYS][SETS];
    int          m_ptr   [SETS];
    logic [31:0] bmem    [logic [31:0]];
    int          exp_hits;
    int          exp_misses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bm_word(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a ^ 32'hC3A5_0F1E;
    endfunction

    function automatic bit m_lookup(input logic [31:0] la, output logic [31:0] d);
        int s;
        s = int'((la >> 2) % SETS);
        d = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (m_valid[i][s] && m_la[i][s] == la) begin
                d = m_data[i][s];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
            end
        end
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic apply_reset();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bm_ack    = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One CPU access with a backing-memory responder of fixed ack latency.
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd, input int lat);
        logic [31:0] la, exp_rd;
        int          s, hw, vic, nx, xi, wcnt, cyc, exp_lat;
        bit          exp_hit;
        bit          xwe [2];
        logic [31:0] xad [2];
        logic [31:0] xwd [2];

        la      = {a[31:2], 2'b00};
        s       = int'((la >> 2) % SETS);
        exp_rd  = '0;
        exp_hit = 1'b0;
        hw      = 0;
        nx      = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (!exp_hit && m_valid[i][s] && m_la[i][s] == la) begin
                exp_hit = 1'b1;
                hw      = i;
            end
        end
        if (exp_hit) begin
            exp_lat = 1;
            if (wr) begin
                m_data[hw][s]  = wd;
                m_dirty[hw][s] = 1'b1;
            end else begin
                exp_rd = m_data[hw][s];
            end
        end else begin
            vic = m_ptr[s];
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[i][s]) vic = i;
            exp_lat = 2;
            if (m_valid[vic][s] && m_dirty[vic][s]) begin
                xwe[nx] = 1'b1;
                xad[nx] = m_la[vic][s];
                xwd[nx] = m_data[vic][s];
                bmem[m_la[vic][s]] = m_data[vic][s];
                nx++;
                exp_lat += 1 + lat;
            end
            if (!wr) begin
                exp_rd  = bm_word(la);
                xwe[nx] = 1'b0;
                xad[nx] = la;
                xwd[nx] = '0;
                nx++;
                exp_lat += 1 + lat;
            end
            if (m_valid[vic][s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            m_valid[vic][s] = 1'b1;
            m_la[vic][s]    = la;
            m_data[vic][s]  = wr ? wd : exp_rd;
            m_dirty[vic][s] = wr;
        end

        mem_write  = wr;
        mem_read   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        addr       = {a[31:2], 2'($urandom_range(0, 3))};
        write_data = wd;
        @(negedge clk);
        addr       = $urandom;
        write_data = $urandom;
        cyc  = 1;
        xi   = 0;
        wcnt = 0;
        while (cyc < 100) begin
            bm_ack = 1'b0;
            if (done) break;
            // Requests while busy must be ignored.
            mem_read  = 1'($urandom_range(0, 1));
            mem_write = 1'($urandom_range(0, 1));
            check("busy_during_miss", busy, 1);
            if (bm_req) begin
                if (wcnt == lat) begin
                    if (xi < nx) begin
                        check("bm_we", bm_we, xwe[xi]);
                        check("bm_addr", bm_addr, xad[xi]);
                        if (xwe[xi]) check("bm_wdata", bm_wdata, xwd[xi]);
                    end else begin
                        check("extra_xfer", xi, nx);
                    end
                    bm_rdata = bm_word(bm_addr);
                    bm_ack   = 1'b1;
                    xi++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bm_ack    = 1'b0;
        check("latency", cyc, exp_lat);
        check("done", done, 1);
        check("hit", hit, exp_hit);
        check("xfer_count", xi, nx);
        check("busy_at_done", busy, 0);
        if (!wr) check("read_data", read_data, exp_rd);
        if (exp_hit) exp_hits++;
        else exp_misses++;
    endtask

    initial begin
        logic [31:0] b2b_addr [4];
        logic [31:0] d;
        bit          ok;
        int          cyc;

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_read_data", read_data, 0);
        check("rst_hit", hit, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_bm_req", bm_req, 0);
        check("rst_bm_we", bm_we, 0);
        check("rst_bm_addr", bm_addr, 0);
        check("rst_bm_wdata", bm_wdata, 0);
        rst = 1'b1;
        model_reset();

        // Clean store miss with no bm traffic, then a hit load.
        do_access(1'b1, 32'h0000_0040, 32'hAABB_CCDD, 0);
        do_access(1'b0, 32'h0000_0040, 32'h0, 0);

        // Load miss filled at 2-cycle ack latency, then a hit reload.
        bmem[32'h0000_1040] = 32'h1234_5678;
        do_access(1'b0, 32'h0000_1040, 32'h0, 2);
        do_access(1'b0, 32'h0000_1040, 32'h0, 0);
        check("fill_value_model", read_data, 32'h1234_5678);

        // Eviction of a dirty way 0, then the survivor hits and the victim misses.
        apply_reset();
        do_access(1'b1, 32'h0000_0040, 32'h1111_0040, 0);
        do_access(1'b1, 32'h0000_0440, 32'h2222_0440, 0);
        do_access(1'b0, 32'h0000_0840, 32'h0, 1);
        do_access(1'b0, 32'h0000_0440, 32'h0, 0);
        do_access(1'b0, 32'h0000_0040, 32'h0, 0);
        check("wb_value_returned", read_data, 32'h1111_0040);

        // Back-to-back hit loads.
        do_access(1'b1, 32'h0000_0004, 32'h0BAD_0004, 0);
        do_access(1'b1, 32'h0000_0008, 32'h0BAD_0008, 0);
        b2b_addr[0] = 32'h0000_0004;
        b2b_addr[1] = 32'h0000_0008;
        b2b_addr[2] = 32'h0000_0040;
        b2b_addr[3] = 32'h0000_0840;
        for (int k = 0; k < 4; k++) begin
            mem_read = 1'b1;
            addr     = b2b_addr[k];
            @(negedge clk);
            ok = m_lookup(b2b_addr[k], d);
            check("b2b_model_hit", 32'(ok), 1);
            check("b2b_done", done, 1);
            check("b2b_hit", hit, 1);
            check("b2b_busy", busy, 0);
            check("b2b_data", read_data, d);
            exp_hits++;
        end
        mem_read = 1'b0;

        // Reset while a fill is outstanding.
        mem_read = 1'b1;
        addr     = 32'h0000_000C;
        @(negedge clk);
        mem_read = 1'b0;
        cyc = 0;
        while (!(bm_req && !bm_we) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("fill_started", 32'(bm_req && !bm_we), 1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_bm_req", bm_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        rst      = 1'b1;
        bm_ack   = 1'b1;
        bm_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bm_ack = 1'b0;
        check("late_ack_bm_req", bm_req, 0);
        check("late_ack_done", done, 0);
        check("late_ack_busy", busy, 0);
        model_reset();
`ifdef CACHE_STATS_EN
        check("stats_rst_hits", hit_count, 0);
        check("stats_rst_misses", miss_count, 0);
`endif
        do_access(1'b0, 32'h0000_0004, 32'h0, 1);
        do_access(1'b0, 32'h0000_0040, 32'h0, 0);
        do_access(1'b0, 32'h0000_0840, 32'h0, 0);

        // Randomised traffic over a small address pool to force evictions.
        for (int k = 0; k < 200; k++) begin
            int t, i;
            t = $urandom_range(0, 5);
            i = $urandom_range(0, 3);
            do_access(1'($urandom_range(0, 1)), 32'(t * 64 + i * 4), $urandom, $urandom_range(0, 2));
        end

`ifdef CACHE_STATS_EN
        check("stats_hits", hit_count, exp_hits);
        check("stats_misses", miss_count, exp_misses);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
